// File: rtl/msgstream_pkg.sv
// rtl/msgstream_pkg.sv - shared state encodings and byte handshake helpers for msgstream
package msgstream_pkg;

    typedef enum logic [1:0] {
        MS_IDLE  = 2'd0,
        MS_FETCH = 2'd1,
        MS_SEND  = 2'd2,
        MS_DONE  = 2'd3
    } ms_state_e;

    localparam int BYTE_W  = 8;
    localparam int COUNT_W = 16;

    // A byte moves to txuart on any cycle where it is offered and txuart is idle.
    function automatic logic hs_accept(input logic stb, input logic busy);
        return stb && !busy;
    endfunction

endpackage

// File: rtl/msgrom.sv
// rtl/msgrom.sv - registered-read message ROM, loaded from a packed parameter image
module msgrom
    import msgstream_pkg::*;
#(
    parameter int                          LGMSG     = 4,
    parameter string                       INIT_FILE = "msg.hex",
    parameter logic [8*(2**LGMSG)-1:0]     INIT_DATA = '0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              rd_en_i,
    input  logic [LGMSG-1:0]  addr_i,
    output logic [BYTE_W-1:0] data_o
);

    logic [BYTE_W-1:0] data_q;

    // Read only when asked so the output byte holds steady while txuart stalls.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_q <= '0;
        end else if (rd_en_i) begin
            data_q <= INIT_DATA[{addr_i, 3'b000} +: BYTE_W];
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/msgstream.sv
// rtl/msgstream.sv - test-message source streaming a ROM message into txuart
module msgstream
    import msgstream_pkg::*;
#(
    parameter int                      MSG_LEN     = 16,
    parameter int                      LGMSG       = 4,
    parameter string                   INIT_FILE   = "msg.hex",
    parameter logic [8*(2**LGMSG)-1:0] INIT_DATA   = '0,
    parameter int                      LGPERIOD    = 28,
    parameter int                      PERIOD      = 2**27,
    parameter bit                      AUTO_REPEAT = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_trigger,
    output logic               o_stb,
    output logic [BYTE_W-1:0]  o_data,
    input  logic               i_busy,
    output logic               o_active,
    output logic               o_done,
    output logic [COUNT_W-1:0] o_count
);

    localparam logic [LGMSG-1:0]    LAST_IDX   = LGMSG'(MSG_LEN - 1);
    localparam logic [LGPERIOD-1:0] PERIOD_MAX = LGPERIOD'(PERIOD - 1);

    ms_state_e            state_q;
    logic [LGMSG-1:0]     index_q;
    logic [LGPERIOD-1:0]  period_q;
    logic [LGPERIOD-1:0]  period_d;
    logic                 stb_q;
    logic                 active_q;
    logic                 done_q;
    logic [COUNT_W-1:0]   count_q;

    logic period_hit;
    logic start;
    logic accept;

    // Trigger and period expiry collapse into one start; neither is remembered outside IDLE.
    assign period_hit = AUTO_REPEAT && i_enable && (period_q == PERIOD_MAX);
    assign start      = (state_q == MS_IDLE) && (i_trigger || period_hit);
    assign accept     = (state_q == MS_SEND) && hs_accept(stb_q, i_busy);

    // Saturating at PERIOD-1 lets an overlong message start its successor right after DONE.
    always_comb begin
        period_d = period_q;
        if (start) begin
            period_d = '0;
        end else if (period_q != PERIOD_MAX) begin
            period_d = period_q + LGPERIOD'(1);
        end
    end

    // Period counter runs in every state so auto starts stay PERIOD clocks apart.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            period_q <= '0;
        end else begin
            period_q <= period_d;
        end
    end

    // Message sequencer: one FETCH per byte, SEND until accepted, DONE pulses once.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= MS_IDLE;
            index_q  <= '0;
            stb_q    <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                MS_IDLE: begin
                    if (start) begin
                        index_q  <= '0;
                        active_q <= 1'b1;
                        state_q  <= MS_FETCH;
                    end
                end
                MS_FETCH: begin
                    stb_q   <= 1'b1;
                    state_q <= MS_SEND;
                end
                MS_SEND: begin
                    if (accept) begin
                        stb_q   <= 1'b0;
                        index_q <= index_q + LGMSG'(1);
                        if (index_q == LAST_IDX) begin
                            active_q <= 1'b0;
                            done_q   <= 1'b1;
                            count_q  <= count_q + COUNT_W'(1);
                            state_q  <= MS_DONE;
                        end else begin
                            state_q <= MS_FETCH;
                        end
                    end
                end
                MS_DONE: begin
                    state_q <= MS_IDLE;
                end
                default: begin
                    state_q <= MS_IDLE;
                end
            endcase
        end
    end

    msgrom #(
        .LGMSG     (LGMSG),
        .INIT_FILE (INIT_FILE),
        .INIT_DATA (INIT_DATA)
    ) u_rom (
        .clk_i   (i_clk),
        .reset_i (i_reset),
        .rd_en_i (state_q == MS_FETCH),
        .addr_i  (index_q),
        .data_o  (o_data)
    );

    assign o_stb    = stb_q;
    assign o_active = active_q;
    assign o_done   = done_q;
    assign o_count  = count_q;

endmodule

// File: tb/tb_msgstream.sv
// tb/tb_msgstream.sv - directed self-checking bench for msgstream
module tb_msgstream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // A: "ABCD", trigger only.  B: "ABCD", auto every 64.  C: 16 bytes, auto every 8.
    logic       rst_a, en_a, trig_a, busy_a, stb_a, act_a, done_a;
    logic [7:0] data_a;
    logic [15:0] cnt_a;
    logic       rst_b, en_b, trig_b, busy_b, stb_b, act_b, done_b;
    logic [7:0] data_b;
    logic [15:0] cnt_b;
    logic       rst_c, en_c, trig_c, busy_c, stb_c, act_c, done_c;
    logic [7:0] data_c;
    logic [15:0] cnt_c;

    msgstream #(.MSG_LEN(4), .LGMSG(2), .INIT_FILE(""), .INIT_DATA(32'h44434241),
                .LGPERIOD(8), .PERIOD(64), .AUTO_REPEAT(1'b0)) dut_a (
        .i_clk(clk), .i_reset(rst_a), .i_enable(en_a), .i_trigger(trig_a),
        .o_stb(stb_a), .o_data(data_a), .i_busy(busy_a), .o_active(act_a),
        .o_done(done_a), .o_count(cnt_a));

    msgstream #(.MSG_LEN(4), .LGMSG(2), .INIT_FILE(""), .INIT_DATA(32'h44434241),
                .LGPERIOD(8), .PERIOD(64), .AUTO_REPEAT(1'b1)) dut_b (
        .i_clk(clk), .i_reset(rst_b), .i_enable(en_b), .i_trigger(trig_b),
        .o_stb(stb_b), .o_data(data_b), .i_busy(busy_b), .o_active(act_b),
        .o_done(done_b), .o_count(cnt_b));

    msgstream #(.MSG_LEN(16), .LGMSG(4), .INIT_FILE(""),
                .INIT_DATA(128'h3F3E3D3C3B3A39383736353433323130),
                .LGPERIOD(8), .PERIOD(8), .AUTO_REPEAT(1'b1)) dut_c (
        .i_clk(clk), .i_reset(rst_c), .i_enable(en_c), .i_trigger(trig_c),
        .o_stb(stb_c), .o_data(data_c), .i_busy(busy_c), .o_active(act_c),
        .o_done(done_c), .o_count(cnt_c));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Trigger A with busy low and check every output cycle by cycle against the t+2k timeline.
    task automatic run_plain_a(input string tag, input logic [15:0] cnt_exp);
        logic exp_stb;
        trig_a = 1'b1;
        step();
        trig_a = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            exp_stb = (k == 2) || (k == 4) || (k == 6) || (k == 8);
            check({tag, "_stb"}, 32'(stb_a), 32'(exp_stb));
            if (exp_stb) check({tag, "_data"}, 32'(data_a), 32'h40 + 32'(k / 2));
            check({tag, "_done"}, 32'(done_a), 32'(k == 9));
            check({tag, "_active"}, 32'(act_a), 32'(k <= 8));
            step();
        end
        check({tag, "_count"}, 32'(cnt_a), 32'(cnt_exp));
    endtask

    function automatic logic pick(input int sel, input bit want_done);
        if (sel == 0) return want_done ? done_b : act_b;
        return want_done ? done_c : act_c;
    endfunction

    // Wait (bounded) for o_active high or an o_done pulse on B (sel 0) or C (sel 1).
    task automatic wait_sig(input string tag, input int sel, input bit want_done, output int at);
        int n;
        n = 0;
        while (!pick(sel, want_done) && n < 400) begin
            step();
            n++;
        end
        check({tag, "_timeout"}, 32'(n >= 400), 32'd0);
        at = cyc;
        if (want_done) step();
    endtask

    initial begin
        int hold, nacc, ndone, nact, s0, s1, s2, s3, d0, d1;
        logic [7:0] cur;
        logic got_done;

        rst_a = 1'b1; en_a = 1'b0; trig_a = 1'b0; busy_a = 1'b0;
        rst_b = 1'b1; en_b = 1'b0; trig_b = 1'b0; busy_b = 1'b0;
        rst_c = 1'b1; en_c = 1'b0; trig_c = 1'b0; busy_c = 1'b0;
        cur = '0;
        repeat (3) step();

        check("rst_stb", 32'(stb_a), 32'd0);
        check("rst_data", 32'(data_a), 32'd0);
        check("rst_active", 32'(act_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_count", 32'(cnt_a), 32'd0);
        rst_a = 1'b0;
        repeat (2) step();

        run_plain_a("t1", 16'd1);

        // Hold busy for five cycles of every SEND; the byte must not move and must arrive in order.
        hold = 0; nacc = 0; got_done = 1'b0;
        trig_a = 1'b1;
        step();
        trig_a = 1'b0;
        for (int k = 0; k < 200 && !got_done; k++) begin
            if (done_a) got_done = 1'b1;
            if (stb_a) begin
                if (hold == 0) cur = data_a;
                else check("t2_hold", 32'(data_a), 32'(cur));
                if (hold < 5) begin
                    busy_a = 1'b1;
                    hold++;
                end else begin
                    busy_a = 1'b0;
                    check("t2_byte", 32'(data_a), 32'h41 + 32'(nacc));
                    nacc++;
                    hold = 0;
                end
            end else begin
                busy_a = 1'b0;
            end
            step();
        end
        busy_a = 1'b0;
        check("t2_done_seen", 32'(got_done), 32'd1);
        check("t2_bytes", 32'(nacc), 32'd4);
        check("t2_count", 32'(cnt_a), 32'd2);
        repeat (2) step();

        // Reset while byte 2 ('C') is on offer.
        trig_a = 1'b1;
        step();
        trig_a = 1'b0;
        for (int k = 0; k < 20 && !(stb_a && data_a == 8'h43); k++) step();
        check("t5_reach_c", 32'(stb_a && data_a == 8'h43), 32'd1);
        rst_a = 1'b1;
        step();
        check("t5_stb", 32'(stb_a), 32'd0);
        check("t5_count", 32'(cnt_a), 32'd0);
        check("t5_active", 32'(act_a), 32'd0);
        rst_a = 1'b0;
        step();
        run_plain_a("t5_restart", 16'd1);

        // Trigger held for 50 cycles: a message every 10 cycles, 5 in all.
        ndone = 0;
        trig_a = 1'b1;
        for (int k = 0; k < 50; k++) begin
            step();
            if (done_a) ndone++;
        end
        trig_a = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (done_a) ndone++;
        end
        check("t6_done_pulses", 32'(ndone), 32'd5);
        check("t6_count", 32'(cnt_a), 32'd6);
        check("t6_idle", 32'(act_a), 32'd0);

        // Auto repeat every 64 clocks, then drop enable mid-message.
        rst_b = 1'b0;
        en_b  = 1'b1;
        wait_sig("t3_s0", 0, 1'b0, s0);
        wait_sig("t3_d0", 0, 1'b1, d0);
        wait_sig("t3_s1", 0, 1'b0, s1);
        wait_sig("t3_d1", 0, 1'b1, d1);
        wait_sig("t3_s2", 0, 1'b0, s2);
        wait_sig("t3_d2", 0, 1'b1, d1);
        check("t3_count3", 32'(cnt_b), 32'd3);
        check("t3_gap01", 32'(s1 - s0), 32'd64);
        check("t3_gap12", 32'(s2 - s1), 32'd64);
        wait_sig("t3_s3", 0, 1'b0, s3);
        check("t3_gap23", 32'(s3 - s2), 32'd64);
        repeat (3) step();
        en_b = 1'b0;
        wait_sig("t3_d3", 0, 1'b1, d1);
        check("t3_count4", 32'(cnt_b), 32'd4);
        nact = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (act_b) nact++;
        end
        check("t3_no_restart", 32'(nact), 32'd0);
        check("t3_count_held", 32'(cnt_b), 32'd4);

        // Message longer than PERIOD: each start lands in the cycle after DONE.
        rst_c = 1'b0;
        en_c  = 1'b1;
        wait_sig("t4_s0", 1, 1'b0, s0);
        wait_sig("t4_d0", 1, 1'b1, d0);
        wait_sig("t4_s1", 1, 1'b0, s1);
        wait_sig("t4_d1", 1, 1'b1, d1);
        wait_sig("t4_s2", 1, 1'b0, s2);
        check("t4_gap_d0", 32'(s1 - d0), 32'd2);
        check("t4_gap_d1", 32'(s2 - d1), 32'd2);
        check("t4_start_spacing", 32'(s1 - s0), 32'd34);
        check("t4_count", 32'(cnt_c), 32'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
